// File: rtl/multiboot_slots.sv
// Multiboot trigger: debounces a boot request, picks one of SLOTS flash addresses or
// a runtime address, and streams the ICAP IPROG sequence with registered ICAP pins.
module multiboot_slots #(
  parameter int                   SLOTS     = 4,
  parameter int                   SLOT_BITS = 2,
  parameter logic [24*SLOTS-1:0]  SLOT_ADDR = {SLOTS{24'd0}},
  parameter int                   QUAD      = 0,
  parameter int                   FILTER    = 3,
  parameter int                   NOOPS     = 4,
  parameter int                   USE_PRIM  = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 boot,
  input  logic [SLOT_BITS-1:0] slot,
  input  logic                 use_ext,
  input  logic [23:0]          ext_addr,
  output logic                 busy,
  output logic                 reject,
  output logic                 icap_ce,
  output logic                 icap_wr,
  output logic [15:0]          icap_din
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  localparam logic [4:0]           LAST    = 5'(10 + 2*QUAD + NOOPS - 1);
  localparam logic [4:0]           TAIL    = 5'(8 + 2*QUAD);
  localparam logic [7:0]           OPCODE  = (QUAD != 0) ? 8'h6B : 8'h03;
  localparam logic [SLOT_BITS:0]   SLOTS_W = (SLOT_BITS+1)'(SLOTS);

  logic                 sync1_r, sync2_r, trig_r;
  logic [FILTER:0]      hist_r;
  logic [0:0]           state_r, state_s;
  logic [4:0]           idx_r, idx_s, widx_s;
  logic [23:0]          addr_r, addr_s;
  logic                 emit_s, reject_s, start_s, slot_ok_s;
  logic [15:0]          word_s;
  logic [23:0]          slot_tbl [2**SLOT_BITS];

  // Slot table padded to the full select range so any slot value indexes safely.
  for (genvar k = 0; k < 2**SLOT_BITS; k++) begin : g_tbl
    if (k < SLOTS) begin : g_used
      assign slot_tbl[k] = SLOT_ADDR[24*k +: 24];
    end else begin : g_pad
      assign slot_tbl[k] = 24'h000000;
    end
  end

  function automatic logic [15:0] rev_bytes(input logic [15:0] w);
    logic [15:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i]     = w[7-i];
      r[8+i]   = w[15-i];
    end
    return r;
  endfunction

  function automatic logic [15:0] word_of(input logic [4:0] i, input logic [23:0] a);
    logic [15:0] w;
    case (i)
      5'd0:    w = 16'hAA99;
      5'd1:    w = 16'h5566;
      5'd2:    w = 16'h30A1;
      5'd3:    w = 16'h0000;
      5'd4:    w = 16'h3261;
      5'd5:    w = a[15:0];
      5'd6:    w = 16'h3281;
      5'd7:    w = {OPCODE, a[23:16]};
      default: begin
        if (QUAD != 0 && i == 5'd8)      w = 16'h3301;
        else if (QUAD != 0 && i == 5'd9) w = 16'h2100;
        else if (i == TAIL)              w = 16'h30A1;
        else if (i == TAIL + 5'd1)       w = 16'h000E;
        else                             w = 16'h2000;
      end
    endcase
    return w;
  endfunction

  assign start_s   = (state_r == IDLE) && !busy && trig_r;
  assign slot_ok_s = use_ext || ({1'b0, slot} < SLOTS_W);
  assign word_s    = word_of(widx_s, addr_r);

  // Next-state and next-word selection; the word goes to the pins one cycle later.
  always_comb begin
    state_s  = state_r;
    idx_s    = idx_r;
    widx_s   = idx_r;
    addr_s   = addr_r;
    emit_s   = 1'b0;
    reject_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start_s && slot_ok_s) begin
          emit_s  = 1'b1;
          widx_s  = 5'd0;
          idx_s   = 5'd1;
          state_s = SEND;
          addr_s  = use_ext ? ext_addr : slot_tbl[slot];
        end else if (start_s) begin
          reject_s = 1'b1;
        end else begin
          idx_s = 5'd0;
        end
      end
      SEND: begin
        emit_s = 1'b1;
        if (idx_r == LAST) begin
          state_s = IDLE;
          idx_s   = 5'd0;
        end else begin
          idx_s = idx_r + 5'd1;
        end
      end
      default: begin
        state_s = IDLE;
        idx_s   = 5'd0;
      end
    endcase
  end

  // Trigger filter, sequencer state and registered ICAP pins.
  always_ff @(posedge clock) begin
    if (!reset) begin
      sync1_r  <= 1'b0;
      sync2_r  <= 1'b0;
      hist_r   <= '0;
      trig_r   <= 1'b0;
      state_r  <= IDLE;
      idx_r    <= 5'd0;
      addr_r   <= 24'h000000;
      busy     <= 1'b0;
      reject   <= 1'b0;
      icap_ce  <= 1'b1;
      icap_wr  <= 1'b1;
      icap_din <= 16'hFFFF;
    end else begin
      sync1_r  <= boot;
      sync2_r  <= sync1_r;
      hist_r   <= {hist_r[FILTER-1:0], sync2_r};
      trig_r   <= hist_r[FILTER] && (hist_r[FILTER-1:0] == '0);
      state_r  <= state_s;
      idx_r    <= idx_s;
      addr_r   <= addr_s;
      busy     <= emit_s;
      reject   <= reject_s;
      icap_ce  <= ~emit_s;
      icap_wr  <= ~emit_s;
      icap_din <= emit_s ? rev_bytes(word_s) : 16'hFFFF;
    end
  end

  if (USE_PRIM != 0) begin : g_prim
`ifdef SYNTHESIS
    ICAP_SPARTAN6 u_icap (
      .BUSY  (),
      .O     (),
      .CE    (icap_ce),
      .CLK   (clock),
      .I     (icap_din),
      .WRITE (icap_wr)
    );
`endif
  end

endmodule

// File: doc/multiboot_slots.md
Name: multiboot_slots

Overview:
- Parametrised successor to the single-address Spartan-6 multiboot trigger. Selects one of SLOTS flash bitstream addresses, or an external runtime address, and drives the ICAP IPROG command sequence.
- Optional quad-SPI (x4) reload mode and a debounced boot trigger.
- Exposes busy/reject status and the registered ICAP bus for verification.
- Sits beside the core top level; the ICAP_SPARTAN6 primitive is instantiated internally when USE_PRIM=1.

Parameters:
- SLOTS, 4, number of selectable bitstream slots (1..16).
- SLOT_BITS, 2, width of slot select; must satisfy 2**SLOT_BITS >= SLOTS.
- SLOT_ADDR, {SLOTS{24'd0}}, packed 24-bit flash addresses; slot k = SLOT_ADDR[24*k+23:24*k].
- QUAD, 0, 1 = use opcode 8'h6B and insert MODE register write (16'h3301, 16'h2100); 0 = opcode 8'h03, no MODE write.
- FILTER, 3, consecutive low samples required after a high sample to fire a trigger (1..8).
- NOOPS, 4, trailing NOOP words after REBOOT (2..15).
- USE_PRIM, 1, 1 = instantiate ICAP_SPARTAN6 driven by icap_* outputs; 0 = ports only (simulation).

Ports:
- clock, in, 1, system clock; also the ICAP clock (<=20 MHz).
- reset, in, 1, synchronous active-low reset.
- boot, in, 1, asynchronous request (button or CPU bit); acts on release.
- slot, in, SLOT_BITS, slot index, sampled at trigger.
- use_ext, in, 1, 1 = use ext_addr instead of slot, sampled at trigger.
- ext_addr, in, 24, runtime flash address, sampled at trigger.
- busy, out, 1, sequence in progress.
- reject, out, 1, one-cycle pulse: trigger fired with use_ext=0 and slot>=SLOTS.
- icap_ce, out, 1, registered ICAP CE (active low).
- icap_wr, out, 1, registered ICAP WRITE (active low = write).
- icap_din, out, 16, registered ICAP data, bit-reversed within each byte.

Behaviour:
- Reset (reset=0 at clock edge) sets:
  - state IDLE, busy=0, reject=0;
  - trigger history all zeros;
  - icap_ce=1, icap_wr=1, icap_din=16'hFFFF;
  - latched address 0.
- Reset mid-sequence aborts. The outputs show the idle values on the cycle after the reset edge, and no partial words are sent afterwards.
- Trigger:
  - boot passes through a 2-flop synchroniser into a history register of FILTER+1 bits.
  - trig is a registered one-cycle pulse. It asserts when the oldest history bit is 1 and the FILTER newer bits are all 0.
  - A held-low boot produces exactly one trig per high-to-low release.
- Trig while busy=1 is ignored; there is no queueing.
- Trig in IDLE:
  - If use_ext=1, latch ext_addr.
  - If use_ext=0 and slot<SLOTS, latch SLOT_ADDR[slot].
  - If use_ext=0 and slot>=SLOTS, pulse reject in the cycle after trig and stay in IDLE.
- Word sequence W, one word per state, advancing every cycle with no BUSY wait:
  - AA99, 5566, 30A1, 0000, 3261, A[15:0], 3281, {OP,A[23:16]};
  - [3301, 2100 if QUAD];
  - 30A1, 000E, then NOOPS x 2000.
  - Length = 10 + 2*QUAD + NOOPS words.
- Output timing:
  - The state machine computes the next word combinationally. icap_* outputs are registered, so there is one cycle latency from state to pins.
  - The first word AA99 appears on icap_din one cycle after the trig cycle.
  - For the first word and every subsequent word, icap_ce=0 and icap_wr=0, on consecutive cycles.
  - After the last NOOP, icap_ce=icap_wr=1 and icap_din=FFFF. The state is IDLE.
- busy:
  - goes 1 in the cycle the first word is on the pins;
  - stays 1 for the whole sequence;
  - goes 0 together with icap_ce returning to 1.
- Bit reversal: icap_din[7:0] = rev(W[7:0]) and icap_din[15:8] = rev(W[15:8]). Examples: AA99 -> 5599, 5566 -> AA66, 30A1 -> 0C85, 000E -> 0070, 2000 -> 0400.
- In hardware, reconfiguration follows REBOOT. A return to IDLE is observable only in simulation or when USE_PRIM=0.

Test Plan:
- Reset then idle: reset=0 for 3 cycles, then release with boot=0 -> icap_ce=1, icap_wr=1, icap_din=FFFF, busy=0; no trig over 100 cycles.
- Slot reload, SLOTS=4, SLOT_ADDR slot2=24'h0B0000, QUAD=0, NOOPS=4: boot high 10 cycles then low with slot=2 -> 14 consecutive words with ce=wr=0. Pre-reversal sequence is AA99, 5566, 30A1, 0000, 3261, 0000, 3281, 030B, 30A1, 000E, 2000x4; pins show 5599, AA66, 0C85, ... Then idle values and busy=0.
- External quad: QUAD=1, use_ext=1, ext_addr=24'h098000 -> 16 words including 3261/8000, 3281/6B09 and 3301/2100 before 30A1/000E.
- Debounce and busy: glitch boot high 1 cycle then low 2 cycles with FILTER=3 -> no sequence. Second release during busy -> ignored, exactly one sequence.
- Invalid slot: SLOTS=3, slot=3, use_ext=0 -> reject pulse exactly 1 cycle; ce stays 1; busy stays 0.
- Abort: reset=0 asserted at word 6 -> next cycle shows idle values. A new trigger then replays the full sequence from AA99.
